bram_delay_ctrl: RTL and testbench

BRAM_DELAY_CTRL -- requirements
Module: bram_delay_ctrl

---
 rtl/bram_delay_ctrl.sv | 137 +++++++++++++
 tb/tb_bram_delay_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_delay_ctrl.sv
// bram_delay_ctrl: address and valid generator for a BRAM used as a
// programmable delay line.
//
// The write pointer runs freely on every ce cycle. The read pointer trails it
// by (delay - LATENCY) locations, so a word appears at the BRAM output exactly
// "delay" ce-cycles after it was written. A two-state FSM (FILL/RUN) holds
// dout_valid low until the ring contains a full delay's worth of fresh data.
//
// Optional feature macro: BRAM_DELAY_CTRL_ERR_CHECK_EN
//   defined   -> err is a sticky flag set by any delay_load whose delay_in is
//                outside the legal range (cleared only by rst_n).
//   undefined -> err is tied low.
// Out-of-range requests are clamped in both builds.

module bram_delay_ctrl #(
   parameter int ADDR_WIDTH    = 9,
   parameter int LATENCY       = 2,
   parameter int DEFAULT_DELAY = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic [ADDR_WIDTH:0]   delay_in,
   input  logic                  delay_load,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  dout_valid,
   output logic                  busy,
   output logic                  err
);

   // Delay values need one bit more than an address: the largest legal delay
   // is 2^ADDR_WIDTH-1+LATENCY.
   localparam int DW          = ADDR_WIDTH + 1;
   localparam int MIN_DELAY_I = LATENCY + 1;
   localparam int MAX_DELAY_I = (1 << ADDR_WIDTH) - 1 + LATENCY;
   localparam int RST_DELAY_I = (DEFAULT_DELAY < MIN_DELAY_I) ? MIN_DELAY_I :
                                (DEFAULT_DELAY > MAX_DELAY_I) ? MAX_DELAY_I :
                                DEFAULT_DELAY;

   localparam logic [DW-1:0] MIN_DELAY = DW'(MIN_DELAY_I);
   localparam logic [DW-1:0] MAX_DELAY = DW'(MAX_DELAY_I);
   localparam logic [DW-1:0] RST_DELAY = DW'(RST_DELAY_I);
   localparam logic [DW-1:0] LAT_W     = DW'(LATENCY);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state;
   logic [DW-1:0]   delay_reg;
   logic [DW-1:0]   fill_cnt;
   logic [DW-1:0]   delay_clamped;
   logic [DW-1:0]   d_eff;

   // The BRAM ports are simply enabled whenever the pipeline advances.
   assign wr_en = ce;
   assign rd_en = ce;
   assign busy  = (state == FILL);

   // Saturate the requested delay into the legal window before capture.
   always_comb begin
      delay_clamped = delay_in;
      if (delay_in < MIN_DELAY) begin
         delay_clamped = MIN_DELAY;
      end else if (delay_in > MAX_DELAY) begin
         delay_clamped = MAX_DELAY;
      end
   end

   // The BRAM's own read latency supplies LATENCY cycles of the delay, so the
   // ring only has to span the remainder; d_eff always fits in ADDR_WIDTH bits.
   always_comb begin
      d_eff   = delay_reg - LAT_W;
      rd_addr = wr_addr - d_eff[ADDR_WIDTH-1:0];
   end

   // Pointer, delay register and FILL/RUN state machine; delay_load overrides
   // FILL completion and is honoured even on ce=0 cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr    <= '0;
         fill_cnt   <= '0;
         state      <= FILL;
         dout_valid <= 1'b0;
         delay_reg  <= RST_DELAY;
      end else begin
         if (ce) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
         end
         if (delay_load) begin
            delay_reg  <= delay_clamped;
            fill_cnt   <= '0;
            state      <= FILL;
            dout_valid <= 1'b0;
         end else if (ce) begin
            case (state)
               FILL: begin
                  fill_cnt <= fill_cnt + DW'(1);
                  if (fill_cnt == delay_reg - DW'(1)) begin
                     state      <= RUN;
                     dout_valid <= 1'b1;
                  end
               end
               RUN: begin
                  dout_valid <= 1'b1;
               end
               default: begin
                  state      <= FILL;
                  dout_valid <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef BRAM_DELAY_CTRL_ERR_CHECK_EN
   logic err_q;

   // Remember any request that had to be clamped until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (delay_load && ((delay_in < MIN_DELAY) || (delay_in > MAX_DELAY))) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Directed bench for bram_delay_ctrl (ADDR_WIDTH=9, LATENCY=2,
// DEFAULT_DELAY=128). A behavioural two-stage BRAM is fed a ramp so the
// delayed output can be compared against the ramp value minus the delay.

module tb_bram_delay_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic [9:0]  delay_in;
   logic        delay_load;
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic        dout_valid;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int exp_n    = 0;   // ce edges since last reset

   logic [15:0] mem [0:511];
   logic [15:0] ramp, p1, p2;

   bram_delay_ctrl #(
      .ADDR_WIDTH   (9),
      .LATENCY      (2),
      .DEFAULT_DELAY(128)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .delay_in  (delay_in),
      .delay_load(delay_load),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .dout_valid(dout_valid),
      .busy      (busy),
      .err       (err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ramp source for the modelled BRAM
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ramp <= '0;
      else if (wr_en) ramp <= ramp + 16'd1;
   end

   // modelled BRAM, two-cycle read latency, both ports gated by the enables
   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= ramp;
      if (rd_en) begin
         p1 <= mem[rd_addr];
         p2 <= p1;
      end
   end

   task automatic tick_ce(input logic c);
      ce = c;
      @(posedge clk);
      if (c) exp_n++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      ce         = 1'b0;
      delay_load = 1'b0;
      delay_in   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_n = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (wr_addr !== 9'd0)     begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
      checks++; if (rd_addr !== 9'd386)   begin failures++; $display("FAIL reset_rd_addr got=%0d exp=386", rd_addr); end
      checks++; if (dout_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
      checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
      checks++; if (err !== 1'b0)         begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b%b exp=00", wr_en, rd_en); end
   endtask

   task automatic test_fill_run();
      for (int n = 1; n <= 140; n++) begin
         tick_ce(1'b1);
         checks++; if (wr_en !== 1'b1 || rd_en !== 1'b1) begin failures++; $display("FAIL fill_en n=%0d got=%b%b exp=11", n, wr_en, rd_en); end
         checks++; if (wr_addr !== 9'(n)) begin failures++; $display("FAIL fill_wr_addr n=%0d got=%0d exp=%0d", n, wr_addr, 9'(n)); end
         checks++; if (rd_addr !== 9'(n - 126)) begin failures++; $display("FAIL fill_rd_addr n=%0d got=%0d exp=%0d", n, rd_addr, 9'(n - 126)); end
         checks++; if (dout_valid !== (n >= 128)) begin failures++; $display("FAIL fill_valid n=%0d got=%b exp=%b", n, dout_valid, (n >= 128)); end
         checks++; if (busy !== (n < 128)) begin failures++; $display("FAIL fill_busy n=%0d got=%b exp=%b", n, busy, (n < 128)); end
         if (n >= 128) begin
            checks++; if (p2 !== 16'(n - 128)) begin failures++; $display("FAIL fill_data n=%0d got=%0d exp=%0d", n, p2, 16'(n - 128)); end
         end
      end
   endtask

   task automatic test_ce_toggle();
      int cyc;
      logic c;
      do_reset();
      cyc = 0;
      while (exp_n < 140 && cyc < 1000) begin
         c = 1'($urandom_range(0, 1));
         tick_ce(c);
         cyc++;
         checks++; if (wr_addr !== 9'(exp_n)) begin failures++; $display("FAIL ce_wr_addr cyc=%0d got=%0d exp=%0d", cyc, wr_addr, 9'(exp_n)); end
         checks++; if (dout_valid !== (exp_n >= 128)) begin failures++; $display("FAIL ce_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, (exp_n >= 128)); end
         if (exp_n >= 128) begin
            checks++; if (p2 !== 16'(exp_n - 128)) begin failures++; $display("FAIL ce_data cyc=%0d got=%0d exp=%0d", cyc, p2, 16'(exp_n - 128)); end
         end
      end
      checks++; if (exp_n < 140) begin failures++; $display("FAIL ce_timeout got=%0d exp=140", exp_n); end
   endtask

   task automatic test_reload();
      delay_in   = 10'd20;
      delay_load = 1'b1;
      tick_ce(1'b1);
      delay_load = 1'b0;
      checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reload_valid got=%b exp=0", dout_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reload_busy got=%b exp=1", busy); end
      checks++; if (wr_addr !== 9'(exp_n)) begin failures++; $display("FAIL reload_wr_addr got=%0d exp=%0d", wr_addr, 9'(exp_n)); end
      for (int k = 1; k <= 25; k++) begin
         tick_ce(1'b1);
         checks++; if (rd_addr !== 9'(exp_n - 18)) begin failures++; $display("FAIL reload_rd_addr k=%0d got=%0d exp=%0d", k, rd_addr, 9'(exp_n - 18)); end
         checks++; if (dout_valid !== (k >= 20)) begin failures++; $display("FAIL reload_valid k=%0d got=%b exp=%b", k, dout_valid, (k >= 20)); end
         if (k >= 20) begin
            checks++; if (p2 !== 16'(exp_n - 20)) begin failures++; $display("FAIL reload_data k=%0d got=%0d exp=%0d", k, p2, 16'(exp_n - 20)); end
         end
      end
   endtask

   task automatic test_clamp();
      logic exp_err;
`ifdef BRAM_DELAY_CTRL_ERR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      // below range: captured as 3, ring offset 1
      delay_in   = 10'd1;
      delay_load = 1'b1;
      tick_ce(1'b1);
      delay_load = 1'b0;
      checks++; if (rd_addr !== 9'(exp_n - 1)) begin failures++; $display("FAIL clamp_lo_rd_addr got=%0d exp=%0d", rd_addr, 9'(exp_n - 1)); end
      checks++; if (err !== exp_err) begin failures++; $display("FAIL clamp_lo_err got=%b exp=%b", err, exp_err); end
      for (int k = 1; k <= 5; k++) begin
         tick_ce(1'b1);
         checks++; if (dout_valid !== (k >= 3)) begin failures++; $display("FAIL clamp_lo_valid k=%0d got=%b exp=%b", k, dout_valid, (k >= 3)); end
         if (k >= 3) begin
            checks++; if (p2 !== 16'(exp_n - 3)) begin failures++; $display("FAIL clamp_lo_data k=%0d got=%0d exp=%0d", k, p2, 16'(exp_n - 3)); end
         end
      end
      // above range: captured as 513, ring offset 511
      delay_in   = 10'd600;
      delay_load = 1'b1;
      tick_ce(1'b1);
      delay_load = 1'b0;
      checks++; if (rd_addr !== 9'(exp_n - 511)) begin failures++; $display("FAIL clamp_hi_rd_addr got=%0d exp=%0d", rd_addr, 9'(exp_n - 511)); end
      checks++; if (err !== exp_err) begin failures++; $display("FAIL clamp_hi_err got=%b exp=%b", err, exp_err); end
      for (int k = 1; k <= 515; k++) begin
         tick_ce(1'b1);
         checks++; if (dout_valid !== (k >= 513)) begin failures++; $display("FAIL clamp_hi_valid k=%0d got=%b exp=%b", k, dout_valid, (k >= 513)); end
         if (k >= 513) begin
            checks++; if (p2 !== 16'(exp_n - 513)) begin failures++; $display("FAIL clamp_hi_data k=%0d got=%0d exp=%0d", k, p2, 16'(exp_n - 513)); end
         end
      end
      do_reset();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL clamp_err_cleared got=%b exp=0", err); end
   endtask

   task automatic test_load_at_completion();
      // load with ce low still captures
      delay_in   = 10'd10;
      delay_load = 1'b1;
      tick_ce(1'b0);
      delay_load = 1'b0;
      checks++; if (wr_addr !== 9'(exp_n)) begin failures++; $display("FAIL cmpl_hold_wr_addr got=%0d exp=%0d", wr_addr, 9'(exp_n)); end
      checks++; if (rd_addr !== 9'(exp_n - 8)) begin failures++; $display("FAIL cmpl_rd_addr got=%0d exp=%0d", rd_addr, 9'(exp_n - 8)); end
      repeat (9) tick_ce(1'b1);
      // this edge would complete FILL; the load must take precedence
      delay_load = 1'b1;
      tick_ce(1'b1);
      delay_load = 1'b0;
      checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL cmpl_valid got=%b exp=0", dout_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cmpl_busy got=%b exp=1", busy); end
      for (int k = 1; k <= 12; k++) begin
         tick_ce(1'b1);
         checks++; if (dout_valid !== (k >= 10)) begin failures++; $display("FAIL cmpl_valid k=%0d got=%b exp=%b", k, dout_valid, (k >= 10)); end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_n = 0;
      checks++; if (wr_addr !== 9'd0)    begin failures++; $display("FAIL areset_wr_addr got=%0d exp=0", wr_addr); end
      checks++; if (rd_addr !== 9'd386)  begin failures++; $display("FAIL areset_rd_addr got=%0d exp=386", rd_addr); end
      checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", dout_valid); end
      checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL areset_busy got=%b exp=1", busy); end
      checks++; if (err !== 1'b0)        begin failures++; $display("FAIL areset_err got=%b exp=0", err); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick_ce(1'b1);
         checks++; if (wr_addr !== 9'(k)) begin failures++; $display("FAIL areset_restart_wr k=%0d got=%0d exp=%0d", k, wr_addr, 9'(k)); end
         checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL areset_restart_valid k=%0d got=%b exp=0", k, dout_valid); end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      ce         = 1'b0;
      delay_in   = '0;
      delay_load = 1'b0;
      test_reset();
      test_fill_run();
      test_ce_toggle();
      test_reload();
      test_clamp();
      test_load_at_completion();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
